// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin front end that time-shares one shifter_32bit
// among NUM_REQ requesters. Each job latches the winner's operands, pulses
// sh_start, waits for sh_done (guarded by a watchdog) and returns the result
// with a one-cycle resp_valid pulse on the granted bit.
module shift_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*32-1:0] req_data,
  input  logic [NUM_REQ*5-1:0] req_amount,
  input  logic [NUM_REQ*2-1:0] req_mode,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 sh_start,
  output logic [31:0]          sh_data_in,
  output logic [4:0]           sh_shift_amount,
  output logic [1:0]           sh_mode,
  input  logic [31:0]          sh_data_out,
  input  logic                 sh_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;       // first index to consider at next arbitration
  logic [IW-1:0]   gidx;      // index of the job currently in flight
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic [CW-1:0]   cnt;       // WAIT-state watchdog
  logic            tmo_hit;

  // ptr + off, wrapped into 0..NUM_REQ-1 (works for non-power-of-2 counts)
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int off);
    logic [IW:0] s;
    s = {1'b0, p} + (IW+1)'(off);
    if (s >= (IW+1)'(NUM_REQ)) s = s - (IW+1)'(NUM_REQ);
    return s[IW-1:0];
  endfunction

  // Round-robin pick: first set req bit scanning upward from ptr with wrap
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!win_found && req[wrap_add(ptr, off)]) begin
        win_idx   = wrap_add(ptr, off);
        win_found = 1'b1;
      end
    end
  end

  assign tmo_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign busy    = (state != S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; done takes priority over the watchdog in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_found) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (sh_done || tmo_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job datapath: operand latch, watchdog, response capture, pointer advance.
  // sh_done is not looked at in ISSUE: the shifter still shows the previous
  // job's done until it sees the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr             <= '0;
      gidx            <= '0;
      cnt             <= '0;
      gnt             <= '0;
      resp_valid      <= '0;
      resp_data       <= '0;
      resp_err        <= 1'b0;
      timeout_err     <= 1'b0;
      sh_start        <= 1'b0;
      sh_data_in      <= '0;
      sh_shift_amount <= '0;
      sh_mode         <= '0;
    end else begin
      sh_start   <= 1'b0;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            gidx            <= win_idx;
            gnt             <= NUM_REQ'(1) << win_idx;
            sh_data_in      <= req_data[32*win_idx +: 32];
            sh_shift_amount <= req_amount[5*win_idx +: 5];
            sh_mode         <= req_mode[2*win_idx +: 2];
            sh_start        <= 1'b1;
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          if (sh_done) begin
            resp_data  <= sh_data_out;
            resp_valid <= gnt;
          end else if (tmo_hit) begin
            resp_data   <= '0;
            resp_valid  <= gnt;
            resp_err    <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: begin
          gnt <= '0;
          ptr <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Round-robin controller that shares one `shifter_32bit` instance among NUM_REQ requesters.
- Typical requesters are neuron leak/decay units in the neuro_int datapath.
- Per job it latches the winner's operands, issues a one-cycle start pulse to the shifter, waits for its done, and routes the result back with a per-requester valid pulse.
- A watchdog counter aborts jobs the shifter never completes.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- TIMEOUT_CYCLES, 40, maximum WAIT-state cycles before a job is aborted (must be > 33).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset; same net also drives shifter rst
- req  in  NUM_REQ  per-requester request level
- req_data  in  NUM_REQ*32  operand, slice i = bits [32i+31:32i]
- req_amount  in  NUM_REQ*5  shift amount per requester
- req_mode  in  NUM_REQ*2  00 LSL, 01 LSR, 10 ASR, 11 pass-through
- gnt  out  NUM_REQ  one-hot grant, high from accept until end of RESP
- resp_valid  out  NUM_REQ  one-cycle pulse on the granted bit
- resp_data  out  32  result, valid while any resp_valid is high
- resp_err  out  1  high with resp_valid when the job timed out
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky timeout flag, cleared only by rst
- sh_start  out  1  start pulse to shifter
- sh_data_in  out  32  latched operand
- sh_shift_amount  out  5  latched amount
- sh_mode  out  2  latched mode
- sh_data_out  in  32  shifter result
- sh_done  in  1  shifter done

Behaviour:
- Reset (sync, rst=1 at an edge):
  - State goes to IDLE; round-robin pointer resets to 0.
  - All outputs are 0, including sh_* operand registers and timeout_err.
  - rst overrides every other event, including mid-job; the in-flight result is discarded with no resp_valid.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, pick the first set bit scanning from pointer upward with wrap.
  - Latch that requester's data/amount/mode into the sh_* registers and set gnt one-hot.
  - Set sh_start=1, go to ISSUE. Otherwise hold.
- ISSUE (exactly one cycle):
  - sh_start drops to 0; timeout counter loads 0; go to WAIT.
  - sh_done sampled in ISSUE is ignored, since the shifter clears done on the start edge.
- WAIT:
  - On sh_done=1: capture sh_data_out into resp_data, pulse resp_valid[granted]=1, resp_err=0, go to RESP.
  - Else, if counter == TIMEOUT_CYCLES-1: resp_data=0, resp_valid pulse, resp_err=1, timeout_err=1, go to RESP.
  - Else increment the counter.
- RESP (one cycle):
  - resp_valid and resp_err are high this cycle only.
  - At the next edge: gnt=0, pointer = granted index + 1 (mod NUM_REQ), go to IDLE.
- Latency: with a conforming shifter and amount k, resp_valid rises k+2 edges after the edge that sets gnt.
  - Next arbitration happens 2 edges after resp_valid rises.
- Operand handling: operands are captured at grant and may change afterwards.
- Requester obligations:
  - Hold req until its resp_valid pulse.
  - Deassert req by the edge after resp_valid falls; a req still high in IDLE is treated as a new request.
- Fairness: a requester waits at most NUM_REQ-1 jobs.
- Other requesters' req toggling during a job has no effect.
- Mode 11: the shifter holds its value, so resp_data = operand after k+2 edges.
- Width: amount is 5 bits; values 0..31 only, no saturation logic.

Test Plan:
- Requester 1: data 0x00000001, amount 3, mode 00 -> gnt=0010; resp_valid[1] 5 edges after gnt; resp_data 0x00000008, resp_err 0.
- Requester 0: 0x80000000, amount 4, mode 10 -> resp_data 0xF8000000. Then amount 4, mode 01 -> 0x08000000. Then amount 0 -> operand returned, resp_valid 2 edges after gnt.
- req=1111 held continuously with per-job req drop/re-raise -> grant order 0,1,2,3,0,1; no requester granted twice before all others served.
- Shifter stubbed with sh_done stuck 0 -> resp_valid after TIMEOUT_CYCLES WAIT cycles; resp_err=1, resp_data 0, timeout_err stays 1 through later good jobs.
- rst pulsed one cycle while in WAIT (amount 20) -> next edge all outputs 0, no resp_valid, pointer 0. A new req=0100 is granted normally with a correct result.
- Operand change right after grant (data 0x1 -> 0xFFFF, amount 2, mode 00) -> result 0x00000004 from the latched operand.
